// File: rtl/piano_voice_controller.sv
// Purpose : polyphonic key-to-voice allocator with per-voice square-wave generators that stop only on a full-cycle boundary.
// Latency : key event sampled at cycle t is reflected on oActive/oOverflow at t+1; first oRing toggle at t+1+half.
// Backpress: none; one event per cycle, a press with no free voice is dropped and flagged on oOverflow.
//
// Ports:
//   iClk, iReset (sync, active-high)
//   iKey_Valid / iKey_Code / iKey_Release / iHalf_Period : decoded key event and its half-period in clocks
//   oRing         : registered OR of all voice waves
//   oActive       : per-voice "not idle" flags
//   oCount_Enable : registered |oActive
//   oOverflow     : one-cycle pulse when a press found no free voice
// Optional feature macro: PIANO_SUSTAIN_EN (hold released voices SUSTAIN_CYCLES extra full cycles).

module piano_voice_controller #(
    parameter int         CHANNELS       = 4,
    parameter int         DIV_W          = 18,
    parameter logic [7:0] STOP_CODE      = 8'd99,
    parameter int         SUSTAIN_CYCLES = 4
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic                iKey_Valid,
    input  logic [7:0]          iKey_Code,
    input  logic                iKey_Release,
    input  logic [DIV_W-1:0]    iHalf_Period,
    output logic                oRing,
    output logic [CHANNELS-1:0] oActive,
    output logic                oCount_Enable,
    output logic                oOverflow
);

    typedef enum logic [1:0] {
        V_IDLE      = 2'd0,
        V_PLAY      = 2'd1,
        V_STOP_PEND = 2'd2
    } voice_state_e;

    voice_state_e        state_q [CHANNELS];
    voice_state_e        state_d [CHANNELS];
    logic [7:0]          code_q  [CHANNELS];
    logic [7:0]          code_d  [CHANNELS];
    logic [DIV_W-1:0]    half_q  [CHANNELS];
    logic [DIV_W-1:0]    half_d  [CHANNELS];
    logic [DIV_W-1:0]    cnt_q   [CHANNELS];
    logic [DIV_W-1:0]    cnt_d   [CHANNELS];
    logic                phase_q [CHANNELS];
    logic                phase_d [CHANNELS];

`ifdef PIANO_SUSTAIN_EN
    localparam int SUS_W = (SUSTAIN_CYCLES < 1) ? 1 : $clog2(SUSTAIN_CYCLES + 1);
    logic [SUS_W-1:0]    sus_q   [CHANNELS];
    logic [SUS_W-1:0]    sus_d   [CHANNELS];
`endif

    logic                ring_q, ring_d;
    logic [CHANNELS-1:0] active_q, active_d;
    logic                cen_q, cen_d;
    logic                ovf_q, ovf_d;

    // Event decode
    logic                is_stop, is_press, is_release;
    logic [CHANNELS-1:0] hit_play, hit_pend, alloc_oh;
    logic                held, free;

    always_comb begin
        is_stop    = iKey_Valid && (iKey_Code == STOP_CODE);
        // Half-periods below 2 cannot form a valid wave; such presses are discarded entirely.
        is_press   = iKey_Valid && !iKey_Release && !is_stop && (iHalf_Period >= DIV_W'(2));
        is_release = iKey_Valid && iKey_Release && !is_stop;
        hit_play   = '0;
        hit_pend   = '0;
        alloc_oh   = '0;
        free       = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit_play[i] = (state_q[i] == V_PLAY)      && (code_q[i] == iKey_Code);
            hit_pend[i] = (state_q[i] == V_STOP_PEND) && (code_q[i] == iKey_Code);
            // Priority pick of the lowest-index idle voice.
            if ((state_q[i] == V_IDLE) && !free) begin
                alloc_oh[i] = 1'b1;
                free        = 1'b1;
            end
        end
        held  = |(hit_play | hit_pend);
        ovf_d = is_press && !held && !free;
    end

    // Per-voice next state: free-running wave progression first, then the key event overrides state.
    always_comb begin
        ring_d   = 1'b0;
        active_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            code_d[i]  = code_q[i];
            half_d[i]  = half_q[i];
            cnt_d[i]   = cnt_q[i];
            phase_d[i] = phase_q[i];
`ifdef PIANO_SUSTAIN_EN
            sus_d[i]   = sus_q[i];
`endif
            if (state_q[i] != V_IDLE) begin
                if (cnt_q[i] == half_q[i] - DIV_W'(1)) begin
                    cnt_d[i]   = '0;
                    phase_d[i] = ~phase_q[i];
                    // A 1->0 wrap closes a full cycle: the only point a pending voice may stop.
                    if ((state_q[i] == V_STOP_PEND) && phase_q[i]) begin
`ifdef PIANO_SUSTAIN_EN
                        if (sus_q[i] == '0) begin
                            state_d[i] = V_IDLE;
                        end else begin
                            sus_d[i] = sus_q[i] - SUS_W'(1);
                        end
`else
                        state_d[i] = V_IDLE;
`endif
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + DIV_W'(1);
                end
            end

            if ((is_stop && (state_q[i] == V_PLAY)) || (is_release && hit_play[i])) begin
                state_d[i] = V_STOP_PEND;
`ifdef PIANO_SUSTAIN_EN
                sus_d[i]   = SUS_W'(SUSTAIN_CYCLES);
`endif
            end

            // Re-press of a pending note: keep the running waveform, just cancel the stop.
            if (is_press && hit_pend[i]) begin
                state_d[i] = V_PLAY;
            end

            if (is_press && !held && alloc_oh[i]) begin
                state_d[i] = V_PLAY;
                code_d[i]  = iKey_Code;
                half_d[i]  = iHalf_Period;
                cnt_d[i]   = '0;
                phase_d[i] = 1'b0;
            end

            active_d[i] = (state_d[i] != V_IDLE);
            ring_d      = ring_d | phase_d[i];
        end
        cen_d = |active_d;
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= V_IDLE;
                code_q[i]  <= '0;
                half_q[i]  <= '0;
                cnt_q[i]   <= '0;
                phase_q[i] <= 1'b0;
`ifdef PIANO_SUSTAIN_EN
                sus_q[i]   <= '0;
`endif
            end
            ring_q   <= 1'b0;
            active_q <= '0;
            cen_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                code_q[i]  <= code_d[i];
                half_q[i]  <= half_d[i];
                cnt_q[i]   <= cnt_d[i];
                phase_q[i] <= phase_d[i];
`ifdef PIANO_SUSTAIN_EN
                sus_q[i]   <= sus_d[i];
`endif
            end
            ring_q   <= ring_d;
            active_q <= active_d;
            cen_q    <= cen_d;
            ovf_q    <= ovf_d;
        end
    end

    assign oRing         = ring_q;
    assign oActive       = active_q;
    assign oCount_Enable = cen_q;
    assign oOverflow     = ovf_q;

endmodule
